// File: rtl/touch_dclk_gen.sv
// Burst/continuous serial clock generator for the resistive touch-panel controller.
// Emits N pulses (or runs until stop) with a programmable half-period, plus edge strobes.
module touch_dclk_gen #(
  parameter int unsigned DIV_W    = 13,
  parameter int unsigned CNT_W    = 6,
  parameter bit          IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  output logic             tp_dclk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic ActLvl = ~IDLE_LVL;

  typedef enum logic [1:0] {StIdle, StPhIdle, StPhAct} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] ph_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] bits_q;
  logic             stop_q;

  logic cont_mode;
  logic phase_end;
  logic last_pulse;

  assign cont_mode = (bits_q == '0);
  assign phase_end = (ph_cnt_q == div_q);
  // A stop seen in the final active cycle still terminates on the upcoming fall.
  assign last_pulse = cont_mode ? (stop_q | stop) : (pulse_cnt == bits_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ph_cnt_q  <= '0;
      div_q     <= '0;
      bits_q    <= '0;
      stop_q    <= 1'b0;
      tp_dclk   <= IDLE_LVL;
      rise_stb  <= 1'b0;
      fall_stb  <= 1'b0;
      pulse_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      done     <= 1'b0;
      if (!en) begin
        // Abort: no done/fall strobe, pulse count is kept for inspection.
        state_q  <= StIdle;
        ph_cnt_q <= '0;
        stop_q   <= 1'b0;
        tp_dclk  <= IDLE_LVL;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // done high means the burst ended this cycle; start waits one more cycle.
            if (start && !done) begin
              div_q     <= div;
              bits_q    <= nbits;
              stop_q    <= stop;
              pulse_cnt <= '0;
              ph_cnt_q  <= '0;
              busy      <= 1'b1;
              state_q   <= StPhIdle;
            end
          end
          StPhIdle: begin
            if (cont_mode) stop_q <= stop_q | stop;
            if (phase_end) begin
              state_q  <= StPhAct;
              ph_cnt_q <= '0;
              tp_dclk  <= ActLvl;
              rise_stb <= 1'b1;
              if (pulse_cnt != '1) pulse_cnt <= pulse_cnt + 1'b1;
            end else begin
              ph_cnt_q <= ph_cnt_q + 1'b1;
            end
          end
          StPhAct: begin
            if (phase_end) begin
              ph_cnt_q <= '0;
              tp_dclk  <= IDLE_LVL;
              fall_stb <= 1'b1;
              if (last_pulse) begin
                state_q <= StIdle;
                stop_q  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_q <= StPhIdle;
              end
            end else begin
              ph_cnt_q <= ph_cnt_q + 1'b1;
              if (cont_mode) stop_q <= stop_q | stop;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_touch_dclk_gen.sv
// Self-checking bench for touch_dclk_gen: scenario table, hand sequences and random bursts
// checked cycle-by-cycle against an arithmetic waveform model (both idle polarities).
module tb_touch_dclk_gen;

  localparam int CntMax = 63;
  localparam int Never  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, start, stop;
  logic [12:0] div;
  logic [5:0]  nbits;

  logic       tp0, r0, f0, b0, d0;
  logic [5:0] c0;
  logic       tp1, r1, f1, b1, d1;
  logic [5:0] c1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  touch_dclk_gen #(.DIV_W(13), .CNT_W(6), .IDLE_LVL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .div(div), .nbits(nbits),
    .tp_dclk(tp0), .rise_stb(r0), .fall_stb(f0), .pulse_cnt(c0), .busy(b0), .done(d0)
  );

  touch_dclk_gen #(.DIV_W(13), .CNT_W(6), .IDLE_LVL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .div(div), .nbits(nbits),
    .tp_dclk(tp1), .rise_stb(r1), .fall_stb(f1), .pulse_cnt(c1), .busy(b1), .done(d1)
  );

  typedef struct {
    int d;
    int n;
    int sc;       // cycle stop is pulsed (-1 none)
    int ab;       // cycle en is dropped (-1 none)
    int exp_cnt;
    int exp_done;
  } vec_t;

  // Model state for the scenario in flight.
  int m_p, m_e, m_endc, m_ab, m_fin, prev_cnt;
  bit m_abort;

  task automatic check(input string name, input int t, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  function automatic int cnt_of(input int phase);
    int c;
    c = (phase + 1) / 2;
    return (c > CntMax) ? CntMax : c;
  endfunction

  // Expected {tp(active), rise, fall, busy, done, cnt} for relative cycle t.
  function automatic logic [10:0] model(input int t);
    logic act, rs, fs, bz, dn;
    int cnt, tau, ph;
    act = 0; rs = 0; fs = 0; bz = 0; dn = 0;
    if (t == 0) begin
      cnt = prev_cnt;
    end else if (t < m_endc) begin
      tau = t - 1;
      ph  = tau / m_p;
      bz  = 1;
      act = (ph % 2) == 1;
      rs  = (tau % m_p == 0) && act;
      fs  = (tau % m_p == 0) && !act && ph > 0;
      cnt = cnt_of(ph);
    end else begin
      cnt = m_fin;
      if (t == m_endc && !m_abort) begin
        fs = 1;
        dn = 1;
      end
    end
    return {act, rs, fs, bz, dn, 6'(cnt)};
  endfunction

  task automatic run_scn(input int d, input int n, input int sc, input int ab, input bit rnd,
                         input string name, output int cnt_fin, output int dones);
    int k, ln;
    logic [10:0] e;
    m_p = d + 1;
    if (n != 0) m_e = 1 + 2 * n * m_p;
    else if (sc >= 0) begin
      k = (sc + 2 * m_p - 1) / (2 * m_p);
      if (k < 1) k = 1;
      m_e = 1 + 2 * k * m_p;
    end else m_e = Never;
    m_abort = (ab >= 1) && (ab < m_e);
    m_ab    = ab;
    m_endc  = m_abort ? ab + 1 : m_e;
    m_fin   = m_abort ? cnt_of((ab - 1) / m_p) : cnt_of(2 * ((m_e - 1) / (2 * m_p)) - 1);
    ln      = m_endc + 3;
    dones   = 0;
    for (int t = 0; t <= ln; t++) begin
      @(negedge clk);
      en    = (t == ab) ? 1'b0 : 1'b1;
      start = (t == 0) || (rnd && t >= 1 && t < m_endc && ($urandom % 4 == 0));
      stop  = (t == sc) || (rnd && n != 0 && ($urandom % 3 == 0));
      div   = (t == 0) ? 13'(d) : 13'($urandom_range(0, 7));
      nbits = (t == 0) ? 6'(n) : 6'($urandom);
      e = model(t);
      check({name, " dut0"}, t, {tp0, r0, f0, b0, d0, c0}, e);
      check({name, " dut1"}, t, {tp1, r1, f1, b1, d1, c1}, {~e[10], e[9:0]});
      if (d0) dones++;
    end
    cnt_fin  = c0;
    prev_cnt = m_fin;
    start = 0; stop = 0; en = 1;
  endtask

  vec_t vecs[9];
  int cf, dn;

  initial begin
    vecs[0] = '{d: 0, n: 3, sc: -1,  ab: -1, exp_cnt: 3,  exp_done: 1};
    vecs[1] = '{d: 4, n: 2, sc: -1,  ab: -1, exp_cnt: 2,  exp_done: 1};
    vecs[2] = '{d: 1, n: 0, sc: 7,   ab: -1, exp_cnt: 2,  exp_done: 1};
    vecs[3] = '{d: 2, n: 8, sc: -1,  ab: 17, exp_cnt: 3,  exp_done: 0};
    vecs[4] = '{d: 0, n: 0, sc: 140, ab: -1, exp_cnt: 63, exp_done: 1};
    vecs[5] = '{d: 1, n: 0, sc: 0,   ab: -1, exp_cnt: 1,  exp_done: 1};
    vecs[6] = '{d: 1, n: 2, sc: 3,   ab: -1, exp_cnt: 2,  exp_done: 1};
    vecs[7] = '{d: 2, n: 0, sc: 6,   ab: -1, exp_cnt: 1,  exp_done: 1};
    vecs[8] = '{d: 2, n: 0, sc: 7,   ab: -1, exp_cnt: 2,  exp_done: 1};

    rst_n = 0; en = 0; start = 0; stop = 0; div = '0; nbits = '0;
    prev_cnt = 0;
    repeat (2) @(negedge clk);
    check("reset dut0", 0, {tp0, r0, f0, b0, d0, c0}, 11'd0);
    check("reset dut1", 0, {tp1, r1, f1, b1, d1, c1}, {1'b1, 10'd0});
    rst_n = 1; en = 1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_scn(vecs[i].d, vecs[i].n, vecs[i].sc, vecs[i].ab, 1'b0, $sformatf("vec%0d", i), cf, dn);
      check($sformatf("vec%0d final cnt", i), i, cf, vecs[i].exp_cnt);
      check($sformatf("vec%0d done count", i), i, dn, vecs[i].exp_done);
    end

    // start held high: bursts of 2+1 cycles separated by the done cycle and one idle cycle.
    @(negedge clk);
    div = 0; nbits = 1; start = 1;
    for (int t = 0; t < 12; t++) begin
      check("hold busy", t, b0, (t % 4 == 1) || (t % 4 == 2));
      check("hold done", t, d0, t % 4 == 3);
      @(negedge clk);
    end
    start = 0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a burst.
    div = 3; nbits = 5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    check("pre-reset busy", 0, b0, 1);
    rst_n = 0;
    #1;
    check("async reset dut0", 0, {tp0, b0, c0}, 8'd0);
    check("async reset dut1", 0, {tp1, b1, c1}, {1'b1, 7'd0});
    @(negedge clk);
    rst_n = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("post-reset idle", t, {b0, d0, r0, f0}, 4'd0);
    end
    prev_cnt = 0;

    for (int i = 0; i < 25; i++) begin
      int d, n, sc, ab;
      d  = $urandom_range(0, 4);
      n  = $urandom_range(0, 5);
      sc = (n == 0) ? $urandom_range(0, 8 * (d + 1)) : -1;
      ab = ($urandom % 4 == 0) ? $urandom_range(1, 30) : -1;
      run_scn(d, n, sc, ab, 1'b1, $sformatf("rnd%0d", i), cf, dn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/touch_dclk_gen.md
Name: touch_dclk_gen

Overview:
Parametrised serial-clock generator for the resistive touch-panel controller interface. It is the successor to the fixed free-running touch-panel DCLK divider. Given a start request, it produces a burst of N clean DCLK pulses with a programmable half-period, or runs continuously until told to stop. It emits one-cycle rise/fall strobes for the shift and sample logic, plus a busy/done handshake to the touch-controller FSM.

Parameters:
DIV_W, 13, width of half-period divisor input
CNT_W, 6, width of pulse-count input/output (max burst 2^CNT_W-1)
IDLE_LVL, 0, tp_dclk level when not busy (0 or 1; idle level and polarity of pulses)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; low forces abort and idle
start  in  1  request a burst; sampled in IDLE only
stop  in  1  continuous-mode stop request; ignored in burst mode
div  in  DIV_W  half-period minus one, in clk cycles; latched at start
nbits  in  CNT_W  pulses per burst; 0 = continuous mode; latched at start
tp_dclk  out  1  serial clock to touch controller
rise_stb  out  1  one-cycle pulse in the first cycle tp_dclk is at active level
fall_stb  out  1  one-cycle pulse in the first cycle tp_dclk returns to idle level
pulse_cnt  out  CNT_W  active edges issued in current burst
busy  out  1  burst in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): tp_dclk=IDLE_LVL; busy, done, rise_stb, fall_stb=0; pulse_cnt=0; state IDLE; div_q, bits_q=0. Release is synchronous to the next clk edge.
- States: IDLE, PH_IDLE (tp_dclk at idle level), PH_ACT (tp_dclk at active level). "Active" = ~IDLE_LVL.
- IDLE: if en && start then latch div_q=div, bits_q=nbits, and clear pulse_cnt. Next cycle: busy=1, state PH_IDLE, phase counter=0.
- Each phase lasts exactly div_q+1 cycles. Full DCLK period = 2*(div_q+1) cycles; div_q=0 gives clk/2.
- PH_IDLE to PH_ACT when the phase counter reaches div_q. In the first PH_ACT cycle: tp_dclk=active, rise_stb=1, pulse_cnt increments (saturating at all-ones in continuous mode).
- PH_ACT to PH_IDLE when the phase counter reaches div_q. In the first new-phase cycle: tp_dclk=idle, fall_stb=1.
- Burst mode (bits_q!=0): on the fall that follows pulse number bits_q, state goes to IDLE. That cycle has fall_stb=1, done=1, busy=0.
- Continuous mode (bits_q==0): a stop seen at any time while busy is latched (stop_q). Termination occurs on the next fall edge, with done as in burst mode. A stop arriving in the same cycle as a fall takes effect on that fall. The block never truncates an active phase.
- nbits=0 with stop already high at start: exactly one pulse, then done.
- en low at any time while busy = abort. Next cycle: tp_dclk=idle, busy=0, state IDLE, stop_q cleared. done and fall_stb are NOT pulsed; pulse_cnt holds its last value.
- start while busy is ignored. div and nbits changes while busy are ignored (latched values are used).
- start in the same cycle done=1: ignored, because the FSM is not yet in IDLE. A new burst may start the cycle after done.
- rise_stb and fall_stb are never high together. done is coincident only with fall_stb.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-burst: rst_n low with busy=1 -> tp_dclk=IDLE_LVL, busy=0, pulse_cnt=0 immediately (async); no done after release.
- div=0, nbits=3, start at cycle 0 -> busy=1 on cycles 1-6; tp_dclk=1 on cycles 2,4,6; rise_stb on 2,4,6; fall_stb on 3,5,7; done=1 and busy=0 on cycle 7; pulse_cnt=3.
- div=4, nbits=2 -> each phase 5 cycles, period 10; busy for 20 cycles; done on the 2nd fall; div changed to 1 mid-burst has no effect on timing.
- Continuous, div=1: start, stop pulsed for 1 cycle midway through an active phase -> that phase completes its 2 cycles; done on the following fall; pulse_cnt equals rises seen.
- Abort: div=2, nbits=8, en dropped after the 3rd rise_stb -> tp_dclk idle and busy=0 the next cycle; no done or fall_stb pulse; pulse_cnt=3.
- Handshake edges: start held high continuously -> a new burst begins the cycle after each done, with exactly one IDLE cycle between bursts. start while busy produces no extra pulses. IDLE_LVL=1 build: all pulses are low-going.
